// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Two-source byte FIFOs with round-robin arbitration feeding UART_TX.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] src0_data,
    input  logic       src0_valid,
    input  logic [7:0] src1_data,
    input  logic       src1_valid,
    input  logic       tx_busy,
    input  logic       clr_ovf,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       src0_full,
    output logic       src1_full,
    output logic       src0_ovf,
    output logic       src1_ovf,
    output logic       timeout_err
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_tw = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_aw-1:0] c_ptr_one    = 1;
    localparam logic [c_aw:0]   c_cnt_one    = 1;
    localparam logic [c_aw:0]   c_full_count = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw-1:0] c_wait_one   = 1;
    localparam logic [c_tw-1:0] c_ack_last   = c_tw'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic [c_tw-1:0] r_wait_cnt;

    logic [7:0] w_wdata [2];
    logic [7:0] w_head  [2];
    logic [1:0] w_wvalid;
    logic [1:0] w_pop;
    logic [1:0] w_ne;
    logic [1:0] w_full;
    logic [1:0] w_ovf;
    logic       w_start;
    logic       w_grant;

    assign w_wdata[0] = src0_data;
    assign w_wdata[1] = src1_data;
    assign w_wvalid   = {src1_valid, src0_valid};

    // On a tie the source not served last wins; otherwise the only non-empty one.
    assign w_start  = (r_state == ST_IDLE) && !tx_busy && (w_ne != 2'b00);
    assign w_grant  = (w_ne == 2'b11) ? ~r_last : w_ne[1];
    assign w_pop[0] = w_start && !w_grant;
    assign w_pop[1] = w_start && w_grant;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_fifo
            logic [7:0]      r_mem [DEPTH];
            logic [c_aw-1:0] r_wr_ptr;
            logic [c_aw-1:0] r_rd_ptr;
            logic [c_aw:0]   r_count;
            logic            r_ovf;
            logic            w_push;
            logic            w_drop;

            assign w_full[s] = (r_count == c_full_count);
            assign w_ne[s]   = (r_count != '0);
            // A pop in the same cycle frees the slot a full-FIFO write needs.
            assign w_push    = w_wvalid[s] && (!w_full[s] || w_pop[s]);
            assign w_drop    = w_wvalid[s] && w_full[s] && !w_pop[s];
            assign w_head[s] = r_mem[r_rd_ptr];
            assign w_ovf[s]  = r_ovf;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_ovf    <= 1'b0;
                end else begin
                    if (w_push)
                        r_wr_ptr <= r_wr_ptr + c_ptr_one;
                    if (w_pop[s])
                        r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    case ({w_push, w_pop[s]})
                        2'b10:   r_count <= r_count + c_cnt_one;
                        2'b01:   r_count <= r_count - c_cnt_one;
                        default: r_count <= r_count;
                    endcase
                    if (w_drop)
                        r_ovf <= 1'b1;
                    else if (clr_ovf)
                        r_ovf <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wr_ptr] <= w_wdata[s];
            end
        end
    endgenerate

    assign src0_full = w_full[0];
    assign src1_full = w_full[1];
    assign src0_ovf  = w_ovf[0];
    assign src1_ovf  = w_ovf[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_wait_cnt  <= '0;
            tx_data     <= 8'h00;
            tx_en       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            if (clr_ovf)
                timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        tx_data <= w_grant ? w_head[1] : w_head[0];
                        r_last  <= w_grant;
                        tx_en   <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_wait_cnt == c_ack_last) begin
                        // Byte is abandoned, not retransmitted.
                        timeout_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Directed vector bench for uart_tx_scheduler with a UART busy model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_scheduler;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic [7:0] src0_data  = 8'h00;
    logic       src0_valid = 1'b0;
    logic [7:0] src1_data  = 8'h00;
    logic       src1_valid = 1'b0;
    logic       tx_busy    = 1'b0;
    logic       clr_ovf    = 1'b0;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       src0_full;
    logic       src1_full;
    logic       src0_ovf;
    logic       src1_ovf;
    logic       timeout_err;

    uart_tx_scheduler #(.DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .src0_data  (src0_data),
        .src0_valid (src0_valid),
        .src1_data  (src1_data),
        .src1_valid (src1_valid),
        .tx_busy    (tx_busy),
        .clr_ovf    (clr_ovf),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .src0_full  (src0_full),
        .src1_full  (src1_full),
        .src0_ovf   (src0_ovf),
        .src1_ovf   (src1_ovf),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // UART model: answers each tx_en with 10 busy cycles; records every strobe.
    int         busy_cnt   = 0;
    bit         force_busy = 1'b0;
    bit         ack_en     = 1'b1;
    logic       prev_en    = 1'b0;
    int         pulse_err  = 0;
    logic [7:0] obs_q[$];
    int         obs_cyc[$];

    always @(negedge clk) begin
        if (tx_en) begin
            obs_q.push_back(tx_data);
            obs_cyc.push_back(cyc);
        end
        if (tx_en && prev_en)
            pulse_err = pulse_err + 1;
        prev_en = tx_en;
        if (tx_en && ack_en)
            busy_cnt = 10;
        else if (busy_cnt > 0)
            busy_cnt = busy_cnt - 1;
        tx_busy = force_busy || (busy_cnt != 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input bit v0, input logic [7:0] d0, input bit v1,
                         input logic [7:0] d1, output int wcyc);
        src0_valid = v0;
        src0_data  = d0;
        src1_valid = v1;
        src1_data  = d1;
        wcyc       = cyc;
        tick();
        src0_valid = 1'b0;
        src1_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int bound, input string name);
        int w = 0;
        while (obs_q.size() < n && w < bound) begin
            tick();
            w = w + 1;
        end
        check({name, " strobe count"}, (obs_q.size() >= n) ? n : obs_q.size(), n);
    endtask

    task automatic obs_clear();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    typedef struct {
        bit         src;
        logic [7:0] data;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];
    int   wc;
    int   t0;
    logic [7:0] exp_b;

    initial begin
        vecs[0] = '{src: 1'b0, data: 8'h41, exp_data: 8'h41, exp_lat: 2};
        vecs[1] = '{src: 1'b1, data: 8'h7E, exp_data: 8'h7E, exp_lat: 2};
        vecs[2] = '{src: 1'b0, data: 8'h00, exp_data: 8'h00, exp_lat: 2};
        vecs[3] = '{src: 1'b1, data: 8'hFF, exp_data: 8'hFF, exp_lat: 2};
        vecs[4] = '{src: 1'b0, data: 8'hA5, exp_data: 8'hA5, exp_lat: 2};
        vecs[5] = '{src: 1'b1, data: 8'h5A, exp_data: 8'h5A, exp_lat: 2};

        // Reset state
        tick();
        check("reset tx_data", tx_data, 8'h00);
        check("reset tx_en", tx_en, 1'b0);
        check("reset src0_full", src0_full, 1'b0);
        check("reset src1_full", src1_full, 1'b0);
        check("reset src0_ovf", src0_ovf, 1'b0);
        check("reset src1_ovf", src1_ovf, 1'b0);
        check("reset timeout_err", timeout_err, 1'b0);
        tick();
        resetn = 1'b1;
        tick();

        // Single-byte vectors: latency, data, hold after SEND
        for (int i = 0; i < 6; i++) begin
            obs_clear();
            write(!vecs[i].src, vecs[i].data, vecs[i].src, vecs[i].data, wc);
            wait_obs(1, 20, $sformatf("vec%0d", i));
            if (obs_q.size() >= 1) begin
                check($sformatf("vec%0d tx_data", i), obs_q[0], vecs[i].exp_data);
                check($sformatf("vec%0d latency", i), obs_cyc[0] - wc, vecs[i].exp_lat);
            end
            repeat (14) tick();
            check($sformatf("vec%0d hold", i), tx_data, vecs[i].exp_data);
        end

        // Contention after reset: source 0 wins the first tie
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        obs_clear();
        write(1'b1, 8'h10, 1'b1, 8'h20, wc);
        write(1'b1, 8'h11, 1'b1, 8'h21, wc);
        wait_obs(4, 100, "contention");
        if (obs_q.size() >= 4) begin
            check("rr order 0", obs_q[0], 8'h10);
            check("rr order 1", obs_q[1], 8'h20);
            check("rr order 2", obs_q[2], 8'h11);
            check("rr order 3", obs_q[3], 8'h21);
        end
        repeat (14) tick();

        // Overflow on source 1 with UART held busy
        obs_clear();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            write(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i), wc);
            if (i == 3) begin
                check("src1_full after 4th", src1_full, 1'b1);
                check("src1_ovf after 4th", src1_ovf, 1'b0);
            end
            if (i == 4)
                check("src1_ovf after 5th", src1_ovf, 1'b1);
        end
        clr_ovf = 1'b1;
        write(1'b0, 8'h00, 1'b1, 8'h3F, wc);
        clr_ovf = 1'b0;
        check("ovf set wins over clr", src1_ovf, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf cleared", src1_ovf, 1'b0);
        force_busy = 1'b0;
        wait_obs(4, 100, "overflow drain");
        for (int i = 0; i < 4; i++) begin
            if (obs_q.size() > i) begin
                exp_b = 8'h30 + 8'(i);
                check($sformatf("ovf drain %0d", i), obs_q[i], exp_b);
            end
        end
        repeat (30) tick();
        check("ovf no extra byte", obs_q.size(), 4);
        check("src1_full after drain", src1_full, 1'b0);

        // Write into a full FIFO in the cycle it is popped
        obs_clear();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++)
            write(1'b1, 8'h51 + 8'(i), 1'b0, 8'h00, wc);
        check("src0_full before pop", src0_full, 1'b1);
        force_busy = 1'b0;
        write(1'b1, 8'h55, 1'b0, 8'h00, wc);
        check("no ovf on full+pop", src0_ovf, 1'b0);
        wait_obs(5, 120, "full+pop");
        for (int i = 0; i < 5; i++) begin
            if (obs_q.size() > i) begin
                exp_b = 8'h51 + 8'(i);
                check($sformatf("full+pop order %0d", i), obs_q[i], exp_b);
            end
        end
        repeat (14) tick();

        // Acknowledge timeout, then the next queued byte goes out
        obs_clear();
        ack_en = 1'b0;
        write(1'b1, 8'hC3, 1'b0, 8'h00, wc);
        write(1'b1, 8'hC4, 1'b0, 8'h00, wc);
        wait_obs(1, 20, "timeout first");
        t0 = (obs_cyc.size() > 0) ? obs_cyc[0] : cyc;
        while (cyc < t0 + 16) tick();
        check("timeout_err before limit", timeout_err, 1'b0);
        tick();
        check("timeout_err at limit", timeout_err, 1'b1);
        ack_en = 1'b1;
        wait_obs(2, 20, "timeout next");
        if (obs_q.size() >= 2) begin
            check("timeout first byte", obs_q[0], 8'hC3);
            check("after timeout byte", obs_q[1], 8'hC4);
            check("after timeout spacing", obs_cyc[1] - t0, 18);
        end
        repeat (14) tick();

        // Reset during WAIT_DONE with three bytes queued
        obs_clear();
        for (int i = 0; i < 4; i++)
            write(1'b1, 8'h61 + 8'(i), 1'b0, 8'h00, wc);
        check("mid-reset one sent", obs_q.size(), 1);
        resetn = 1'b0;
        #1;
        check("mid-reset tx_data", tx_data, 8'h00);
        check("mid-reset tx_en", tx_en, 1'b0);
        check("mid-reset src0_full", src0_full, 1'b0);
        check("mid-reset timeout_err", timeout_err, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        repeat (40) tick();
        check("no tx after reset", obs_q.size(), 1);
        write(1'b0, 8'h00, 1'b1, 8'h99, wc);
        wait_obs(2, 40, "post-reset");
        if (obs_q.size() >= 2)
            check("post-reset byte", obs_q[1], 8'h99);
        repeat (14) tick();

        check("tx_en single-cycle pulses", pulse_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
